// File: rtl/rat_ckpt_pkg.sv
// Shared constants and entry types for the checkpointed register alias table.
// The optional retirement RAT is enabled by defining RAT_RRAT_EN.
package rat_ckpt_pkg;

    localparam int ARCH_REGS     = 32;
    localparam int ARCH_BITS     = 5;
    localparam int RAT_PHYS_BITS = 6;

    typedef struct packed {
        logic [RAT_PHYS_BITS-1:0] map;
        logic                     valid;
    } rat_entry_t;

    typedef rat_entry_t [ARCH_REGS-1:0] rat_image_t;

endpackage

// File: rtl/rat_ckpt_if.sv
// Rename / wakeup / checkpoint bus between dispatch and the RAT.
// Commit and flush signals exist only when RAT_RRAT_EN is defined.
interface rat_ckpt_if
    import rat_ckpt_pkg::*;
#(
    parameter int PHYS_REG_BITS = 6,
    parameter int NUM_CDB       = 3,
    parameter int CKPT_BITS     = 2
);
    logic [ARCH_BITS-1:0]             rs1;
    logic [ARCH_BITS-1:0]             rs2;
    logic [PHYS_REG_BITS-1:0]         ps1;
    logic [PHYS_REG_BITS-1:0]         ps2;
    logic                             ps1_valid;
    logic                             ps2_valid;
    logic                             dispatch_we;
    logic [ARCH_BITS-1:0]             rd_dispatch;
    logic [PHYS_REG_BITS-1:0]         pd_dispatch;
    logic [NUM_CDB-1:0]               cdb_valid;
    logic [NUM_CDB*PHYS_REG_BITS-1:0] cdb_pd;
    logic                             ckpt_req;
    logic                             ckpt_ready;
    logic [CKPT_BITS-1:0]             ckpt_id;
    logic                             ckpt_free_valid;
    logic [CKPT_BITS-1:0]             ckpt_free_id;
    logic                             restore_valid;
    logic [CKPT_BITS-1:0]             restore_id;
`ifdef RAT_RRAT_EN
    logic                             commit_valid;
    logic [ARCH_BITS-1:0]             commit_rd;
    logic [PHYS_REG_BITS-1:0]         commit_pd;
    logic                             flush;
`endif

    modport master (
        output rs1, rs2, dispatch_we, rd_dispatch, pd_dispatch, cdb_valid, cdb_pd,
        output ckpt_req, ckpt_free_valid, ckpt_free_id, restore_valid, restore_id,
`ifdef RAT_RRAT_EN
        output commit_valid, commit_rd, commit_pd, flush,
`endif
        input  ps1, ps2, ps1_valid, ps2_valid, ckpt_ready, ckpt_id
    );

    modport slave (
        input  rs1, rs2, dispatch_we, rd_dispatch, pd_dispatch, cdb_valid, cdb_pd,
        input  ckpt_req, ckpt_free_valid, ckpt_free_id, restore_valid, restore_id,
`ifdef RAT_RRAT_EN
        input  commit_valid, commit_rd, commit_pd, flush,
`endif
        output ps1, ps2, ps1_valid, ps2_valid, ckpt_ready, ckpt_id
    );

endinterface

// File: rtl/rat_ckpt_alloc.sv
// Checkpoint slot bookkeeping: free bitmap, lowest-free grant and age ordering
// through younger masks so a restore squashes every later-taken checkpoint.
module rat_ckpt_alloc
    import rat_ckpt_pkg::*;
#(
    parameter int NUM_CKPT  = 4,
    parameter int CKPT_BITS = $clog2(NUM_CKPT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_i,
    input  logic                 free_valid_i,
    input  logic [CKPT_BITS-1:0] free_id_i,
    input  logic                 restore_valid_i,
    input  logic [CKPT_BITS-1:0] restore_id_i,
    input  logic                 flush_i,
    output logic                 ready_o,
    output logic [CKPT_BITS-1:0] id_o,
    output logic [NUM_CKPT-1:0]  allocated_o
);
    logic [NUM_CKPT-1:0] alloc_q, alloc_d;
    logic [NUM_CKPT-1:0] younger_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] younger_d [NUM_CKPT];
    logic [NUM_CKPT-1:0] release_mask;

    always_comb begin
        ready_o = ~&alloc_q;
        id_o    = '0;
        for (int i = NUM_CKPT-1; i >= 0; i--) begin
            if (!alloc_q[i]) id_o = CKPT_BITS'(i);
        end
    end

    always_comb begin
        release_mask = '0;
        if (restore_valid_i) begin
            release_mask = younger_q[restore_id_i] | (NUM_CKPT'(1) << restore_id_i);
        end
        if (free_valid_i) release_mask[free_id_i] = 1'b1;

        alloc_d = alloc_q & ~release_mask;
        for (int i = 0; i < NUM_CKPT; i++) younger_d[i] = younger_q[i] & ~release_mask;

        // The new slot is younger than every slot still live after this cycle's releases.
        if (alloc_i) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (alloc_d[i]) younger_d[i][id_o] = 1'b1;
            end
            younger_d[id_o] = '0;
            alloc_d[id_o]   = 1'b1;
        end

        if (flush_i) begin
            alloc_d = '0;
            for (int i = 0; i < NUM_CKPT; i++) younger_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_q <= '0;
            for (int i = 0; i < NUM_CKPT; i++) younger_q[i] <= '0;
        end else begin
            alloc_q   <= alloc_d;
            younger_q <= younger_d;
            assert (!(free_valid_i && !alloc_q[free_id_i]));
        end
    end

    assign allocated_o = alloc_q;

endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with CDB wakeup and single-cycle branch checkpoint restore.
// Define RAT_RRAT_EN to add a retirement RAT with commit and full flush.
module rat_ckpt
    import rat_ckpt_pkg::*;
#(
    parameter int PHYS_REG_BITS = RAT_PHYS_BITS,
    parameter int NUM_CDB       = 3,
    parameter int NUM_CKPT      = 4,
    parameter int CKPT_BITS     = $clog2(NUM_CKPT)
) (
    input  logic     clk,
    input  logic     rst,
    rat_ckpt_if.slave bus
);
    typedef struct packed {
        logic [PHYS_REG_BITS-1:0] map;
        logic                     valid;
    } entry_t;
    typedef entry_t [ARCH_REGS-1:0] image_t;

    image_t               live_q, live_d;
    image_t               ckpt_q [NUM_CKPT];
    image_t               ckpt_d [NUM_CKPT];
    logic [ARCH_REGS-1:0] live_hit;
    logic [ARCH_REGS-1:0] ckpt_hit [NUM_CKPT];
    logic [NUM_CKPT-1:0]  allocated;
    logic                 ckpt_ready, alloc_fire, flush;
    logic [CKPT_BITS-1:0] ckpt_id;

    function automatic logic cdb_match(input logic [PHYS_REG_BITS-1:0] tag,
                                       input logic [NUM_CDB-1:0] v,
                                       input logic [NUM_CDB*PHYS_REG_BITS-1:0] pd);
        logic m;
        m = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (v[k] && pd[k*PHYS_REG_BITS +: PHYS_REG_BITS] == tag) m = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            live_hit[i] = cdb_match(live_q[i].map, bus.cdb_valid, bus.cdb_pd);
        end
        for (int c = 0; c < NUM_CKPT; c++) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                ckpt_hit[c][i] = cdb_match(ckpt_q[c][i].map, bus.cdb_valid, bus.cdb_pd);
            end
        end
    end

`ifdef RAT_RRAT_EN
    logic [PHYS_REG_BITS-1:0] rrat_q [ARCH_REGS];
    logic [PHYS_REG_BITS-1:0] rrat_d [ARCH_REGS];

    always_comb begin
        rrat_d = rrat_q;
        if (bus.commit_valid && bus.commit_rd != '0) rrat_d[bus.commit_rd] = bus.commit_pd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) rrat_q[i] <= PHYS_REG_BITS'(i);
        end else begin
            rrat_q <= rrat_d;
        end
    end

    assign flush = bus.flush;
`else
    assign flush = 1'b0;
`endif

    assign alloc_fire = bus.ckpt_req && ckpt_ready && !bus.restore_valid && !flush;

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            live_d[i].map   = live_q[i].map;
            live_d[i].valid = live_q[i].valid | live_hit[i];
        end
`ifdef RAT_RRAT_EN
        if (flush) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                live_d[i].map   = rrat_d[i];
                live_d[i].valid = 1'b1;
            end
        end else
`endif
        if (bus.restore_valid) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                live_d[i].map   = ckpt_q[bus.restore_id][i].map;
                live_d[i].valid = ckpt_q[bus.restore_id][i].valid | ckpt_hit[bus.restore_id][i];
            end
        end else if (bus.dispatch_we && bus.rd_dispatch != '0) begin
            live_d[bus.rd_dispatch].map   = bus.pd_dispatch;
            live_d[bus.rd_dispatch].valid = 1'b0;
        end
        live_d[0].map   = '0;
        live_d[0].valid = 1'b1;
    end

    // Snapshot takes the post-update image so a same-cycle link-register rename survives restore.
    always_comb begin
        for (int c = 0; c < NUM_CKPT; c++) begin
            ckpt_d[c] = ckpt_q[c];
            for (int i = 0; i < ARCH_REGS; i++) begin
                if (allocated[c] && ckpt_hit[c][i]) ckpt_d[c][i].valid = 1'b1;
            end
        end
        if (alloc_fire) ckpt_d[ckpt_id] = live_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                live_q[i].map   <= PHYS_REG_BITS'(i);
                live_q[i].valid <= 1'b1;
            end
        end else begin
            live_q <= live_d;
            assert (!(bus.ckpt_req && !ckpt_ready && !bus.restore_valid && !flush));
            assert (!(bus.ckpt_free_valid && bus.restore_valid &&
                      bus.ckpt_free_id == bus.restore_id));
        end
    end

    always_ff @(posedge clk) begin
        ckpt_q <= ckpt_d;
    end

    always_comb begin
        bus.ps1       = '0;
        bus.ps1_valid = 1'b1;
        bus.ps2       = '0;
        bus.ps2_valid = 1'b1;
        if (bus.rs1 != '0) begin
            bus.ps1       = live_q[bus.rs1].map;
            bus.ps1_valid = live_q[bus.rs1].valid | live_hit[bus.rs1];
        end
        if (bus.rs2 != '0) begin
            bus.ps2       = live_q[bus.rs2].map;
            bus.ps2_valid = live_q[bus.rs2].valid | live_hit[bus.rs2];
        end
    end

    rat_ckpt_alloc #(
        .NUM_CKPT  (NUM_CKPT),
        .CKPT_BITS (CKPT_BITS)
    ) u_alloc (
        .clk             (clk),
        .rst             (rst),
        .alloc_i         (alloc_fire),
        .free_valid_i    (bus.ckpt_free_valid),
        .free_id_i       (bus.ckpt_free_id),
        .restore_valid_i (bus.restore_valid && !flush),
        .restore_id_i    (bus.restore_id),
        .flush_i         (flush),
        .ready_o         (ckpt_ready),
        .id_o            (ckpt_id),
        .allocated_o     (allocated)
    );

    assign bus.ckpt_ready = ckpt_ready;
    assign bus.ckpt_id    = ckpt_id;

endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: directed vector table followed by random traffic checked
// against an age-ordered checkpoint model.
module tb_rat_ckpt;
    import rat_ckpt_pkg::*;

    localparam int PB = 6;
    localparam int NC = 3;
    localparam int NK = 4;
    localparam int KB = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rat_ckpt_if #(.PHYS_REG_BITS(PB), .NUM_CDB(NC), .CKPT_BITS(KB)) bus();

    rat_ckpt #(.PHYS_REG_BITS(PB), .NUM_CDB(NC), .NUM_CKPT(NK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic               we;
        logic [4:0]         rd;
        logic [PB-1:0]      pd;
        logic [NC-1:0]      cdbv;
        logic [NC-1:0][PB-1:0] tags;
        logic               ckreq;
        logic               rsv;
        logic [KB-1:0]      rsid;
        logic               frv;
        logic [KB-1:0]      frid;
        logic [PB-1:0]      e_ps1;
        logic               e_v1;
        logic [PB-1:0]      e_ps2;
        logic               e_v2;
        logic               e_rdy;
        logic [KB-1:0]      e_id;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model: images as plain arrays, checkpoint order by allocation age
    int m_map [32];
    bit m_val [32];
    int c_map [NK][32];
    bit c_val [NK][32];
    bit c_used [NK];
    int c_age [NK];
    int age_ctr;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t row(int rs1, int rs2, int we, int rd, int pd, int cdbv, int tag,
                                 int ck, int rsv, int rsid, int frv, int frid,
                                 int e1, int v1, int e2, int v2, int rdy, int id);
        vec_t v;
        v = '0;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.we = 1'(we); v.rd = 5'(rd); v.pd = PB'(pd);
        v.cdbv = NC'(cdbv);
        for (int k = 0; k < NC; k++) v.tags[k] = v.cdbv[k] ? PB'(tag) : PB'(63);
        v.ckreq = 1'(ck); v.rsv = 1'(rsv); v.rsid = KB'(rsid); v.frv = 1'(frv); v.frid = KB'(frid);
        v.e_ps1 = PB'(e1); v.e_v1 = 1'(v1); v.e_ps2 = PB'(e2); v.e_v2 = 1'(v2);
        v.e_rdy = 1'(rdy); v.e_id = KB'(id);
        return v;
    endfunction

    function automatic bit woke(vec_t v, int tag);
        for (int k = 0; k < NC; k++) begin
            if (v.cdbv[k] && int'(v.tags[k]) == tag) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int lowest_free();
        for (int c = 0; c < NK; c++) begin
            if (!c_used[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_map[i] = i;
            m_val[i] = 1'b1;
        end
        for (int c = 0; c < NK; c++) c_used[c] = 1'b0;
        age_ctr = 0;
    endtask

    task automatic model_step(vec_t v);
        int nm [32];
        bit nv [32];
        int lf;
        int ra;
        int r;
        lf = lowest_free();
        ra = 0;
        r  = int'(v.rsid);
        for (int i = 0; i < 32; i++) begin
            nm[i] = m_map[i];
            nv[i] = m_val[i] | woke(v, m_map[i]);
        end
        if (v.rsv) begin
            ra = c_age[r];
            for (int i = 0; i < 32; i++) begin
                nm[i] = c_map[r][i];
                nv[i] = c_val[r][i] | woke(v, c_map[r][i]);
            end
        end else if (v.we && v.rd != 0) begin
            nm[v.rd] = int'(v.pd);
            nv[v.rd] = 1'b0;
        end
        nm[0] = 0;
        nv[0] = 1'b1;
        for (int c = 0; c < NK; c++) begin
            if (c_used[c]) begin
                for (int i = 0; i < 32; i++) begin
                    if (woke(v, c_map[c][i])) c_val[c][i] = 1'b1;
                end
            end
        end
        if (v.frv) c_used[v.frid] = 1'b0;
        if (v.rsv) begin
            for (int c = 0; c < NK; c++) begin
                if (c_used[c] && c_age[c] > ra) c_used[c] = 1'b0;
            end
            c_used[r] = 1'b0;
        end
        if (v.ckreq && !v.rsv && lf >= 0) begin
            c_used[lf] = 1'b1;
            c_age[lf]  = age_ctr;
            age_ctr++;
            for (int i = 0; i < 32; i++) begin
                c_map[lf][i] = nm[i];
                c_val[lf][i] = nv[i];
            end
        end
        for (int i = 0; i < 32; i++) begin
            m_map[i] = nm[i];
            m_val[i] = nv[i];
        end
    endtask

    task automatic drive(vec_t v);
        bus.rs1             = v.rs1;
        bus.rs2             = v.rs2;
        bus.dispatch_we     = v.we;
        bus.rd_dispatch     = v.rd;
        bus.pd_dispatch     = v.pd;
        bus.cdb_valid       = v.cdbv;
        bus.cdb_pd          = v.tags;
        bus.ckpt_req        = v.ckreq;
        bus.restore_valid   = v.rsv;
        bus.restore_id      = v.rsid;
        bus.ckpt_free_valid = v.frv;
        bus.ckpt_free_id    = v.frid;
    endtask

    // Drive one cycle, check combinational outputs mid-cycle, advance the model with the edge.
    task automatic apply(vec_t v, bit use_model, string nm);
        int lf;
        drive(v);
        #2;
        if (use_model) begin
            lf = lowest_free();
            v.e_ps1 = (v.rs1 == 0) ? '0 : PB'(m_map[v.rs1]);
            v.e_v1  = (v.rs1 == 0) || m_val[v.rs1] || woke(v, m_map[v.rs1]);
            v.e_ps2 = (v.rs2 == 0) ? '0 : PB'(m_map[v.rs2]);
            v.e_v2  = (v.rs2 == 0) || m_val[v.rs2] || woke(v, m_map[v.rs2]);
            v.e_rdy = (lf >= 0);
            v.e_id  = KB'(lf);
        end
        chk({nm, " ps1"}, int'(bus.ps1), int'(v.e_ps1));
        chk({nm, " ps1_valid"}, int'(bus.ps1_valid), int'(v.e_v1));
        chk({nm, " ps2"}, int'(bus.ps2), int'(v.e_ps2));
        chk({nm, " ps2_valid"}, int'(bus.ps2_valid), int'(v.e_v2));
        chk({nm, " ckpt_ready"}, int'(bus.ckpt_ready), int'(v.e_rdy));
        if (v.e_rdy) chk({nm, " ckpt_id"}, int'(bus.ckpt_id), int'(v.e_id));
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int used_q[$];
        int lf;
        int pick;
        v  = '0;
        lf = lowest_free();
        for (int c = 0; c < NK; c++) if (c_used[c]) used_q.push_back(c);
        v.rs1  = 5'($urandom_range(0, 31));
        v.rs2  = 5'($urandom_range(0, 31));
        v.we   = 1'($urandom_range(0, 1));
        v.rd   = 5'($urandom_range(0, 31));
        v.pd   = PB'($urandom_range(0, 63));
        v.cdbv = NC'($urandom_range(0, 7));
        for (int k = 0; k < NC; k++) begin
            if ($urandom_range(0, 9) < 7) v.tags[k] = PB'(m_map[$urandom_range(0, 31)]);
            else                          v.tags[k] = PB'($urandom_range(0, 63));
        end
        if (used_q.size() > 0 && $urandom_range(0, 9) == 0) begin
            v.rsv  = 1'b1;
            v.rsid = KB'(used_q[$urandom_range(0, used_q.size()-1)]);
        end
        if (used_q.size() > 0 && $urandom_range(0, 6) == 0) begin
            pick = used_q[$urandom_range(0, used_q.size()-1)];
            if (!(v.rsv && KB'(pick) == v.rsid)) begin
                v.frv  = 1'b1;
                v.frid = KB'(pick);
            end
        end
        if (lf >= 0 && $urandom_range(0, 2) == 0) v.ckreq = 1'b1;
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        //        rs1 rs2 we rd pd  cdbv  tag ck rv ri fv fi | ps1 v1 ps2 v2 rdy id
        tbl.push_back(row(5, 7, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0,  5, 1, 7, 1, 1, 0));
        tbl.push_back(row(5, 0, 1, 5, 40, 0,    0, 0, 0, 0, 0, 0,  5, 1, 0, 1, 1, 0));
        tbl.push_back(row(5, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 40, 0, 0, 1, 1, 0));
        tbl.push_back(row(5, 0, 0, 0, 0,  3'b010, 40, 0, 0, 0, 0, 0, 40, 1, 0, 1, 1, 0));
        tbl.push_back(row(5, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 40, 1, 0, 1, 1, 0));
        tbl.push_back(row(3, 5, 1, 3, 33, 0,    0, 1, 0, 0, 0, 0,  3, 1, 40, 1, 1, 0));
        tbl.push_back(row(3, 0, 1, 3, 34, 0,    0, 1, 0, 0, 0, 0, 33, 0, 0, 1, 1, 1));
        tbl.push_back(row(3, 0, 1, 3, 35, 0,    0, 0, 0, 0, 0, 0, 34, 0, 0, 1, 1, 2));
        tbl.push_back(row(3, 0, 0, 0, 0,  0,    0, 0, 1, 0, 0, 0, 35, 0, 0, 1, 1, 2));
        tbl.push_back(row(3, 5, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 33, 0, 40, 1, 1, 0));
        tbl.push_back(row(9, 0, 1, 9, 50, 0,    0, 1, 0, 0, 0, 0,  9, 1, 0, 1, 1, 0));
        tbl.push_back(row(9, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 50, 0, 0, 1, 1, 1));
        tbl.push_back(row(9, 0, 0, 0, 0,  3'b100, 50, 0, 0, 0, 0, 0, 50, 1, 0, 1, 1, 1));
        tbl.push_back(row(9, 0, 0, 0, 0,  0,    0, 0, 1, 0, 0, 0, 50, 1, 0, 1, 1, 1));
        tbl.push_back(row(9, 3, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 50, 1, 33, 0, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 2));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 1, 0, 0, 0, 0,  0, 1, 0, 1, 1, 3));
        tbl.push_back(row(3, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 33, 0, 0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 0, 0, 0, 1, 2,  0, 1, 0, 1, 0, 0));
        tbl.push_back(row(0, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 2));
        tbl.push_back(row(4, 0, 1, 4, 60, 0,    0, 1, 1, 1, 0, 0,  4, 1, 0, 1, 1, 2));
        tbl.push_back(row(4, 9, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0,  4, 1, 50, 1, 1, 1));
        tbl.push_back(row(0, 0, 1, 0, 61, 0,    0, 0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1));
        tbl.push_back(row(0, 4, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0,  0, 1, 4, 1, 1, 1));
        tbl.push_back(row(5, 0, 1, 5, 42, 0,    0, 0, 0, 0, 0, 0, 40, 1, 0, 1, 1, 1));
        tbl.push_back(row(5, 0, 1, 5, 41, 3'b001, 42, 0, 0, 0, 0, 0, 42, 1, 0, 1, 1, 1));
        tbl.push_back(row(5, 0, 0, 0, 0,  0,    0, 0, 0, 0, 0, 0, 41, 0, 0, 1, 1, 1));

`ifdef RAT_RRAT_EN
        bus.commit_valid = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_pd    = '0;
        bus.flush        = 1'b0;
`endif
        drive('0);
        rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], 1'b0, $sformatf("row%0d", i));
        end

        for (int n = 0; n < 2000; n++) begin
            apply(rand_vec(), 1'b1, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
